// File: rtl/exec_cdb_broadcaster.sv
// Execution back end: fixed-latency 64-bit ALU pipeline feeding an in-order
// result buffer that broadcasts {tag, value} on the common data bus.
// Credit-based back-pressure (stall_o) keeps the buffer from overflowing.
module exec_cdb_broadcaster #(
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int LATENCY    = 3,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [63:0]           rsVal1_i,
    input  logic [63:0]           rsVal2_i,
    input  logic [9:0]            rsCommands_i,
    input  logic [ROBsizeLog-1:0] rsTag_i,
    input  logic                  rsReady_i,
    output logic                  stall_o,
    input  logic                  cdbGrant_i,
    output logic                  cdbReq_o,
    output logic [ROBsizeLog-1:0] cdbTag_o,
    output logic [64:0]           cdbVal_o
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

    // Circular-buffer pointer increment with explicit wrap at BUF_DEPTH-1.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            next_ptr = {PTR_W{1'b0}};
        end else begin
            next_ptr = p + {{(PTR_W-1){1'b0}}, 1'b1};
        end
    endfunction

    logic [OCC_W-1:0]      occ_r;
    logic                  stall_s;
    logic                  acc_s;
    logic                  pop_s;
    logic [63:0]           alu_s;
    logic                  wr_vld_s;
    logic [ROBsizeLog-1:0] wr_tag_s;
    logic [63:0]           wr_res_s;

    logic [ROBsizeLog-1:0] tag_mem_r [BUF_DEPTH];
    logic [63:0]           res_mem_r [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [OCC_W-1:0]      cnt_r;

    // No same-cycle credit return: stall depends only on the registered count.
    assign stall_s = reset_i | (occ_r == OCC_FULL);
    assign stall_o = stall_s;
    assign acc_s   = rsReady_i & ~stall_s;
    // Grant only pops an entry that is already visible at the buffer head.
    assign pop_s   = (cnt_r != {OCC_W{1'b0}}) & cdbGrant_i;

    // Execute the opcode on the issued operands at acceptance time.
    always_comb begin
        alu_s = 64'd0;
        case (rsCommands_i[2:0])
            3'd0:    alu_s = rsVal1_i + rsVal2_i;
            3'd1:    alu_s = rsVal1_i - rsVal2_i;
            3'd2:    alu_s = rsVal1_i & rsVal2_i;
            3'd3:    alu_s = rsVal1_i | rsVal2_i;
            3'd4:    alu_s = rsVal1_i ^ rsVal2_i;
            3'd5:    alu_s = rsVal1_i << rsVal2_i[5:0];
            3'd6:    alu_s = rsVal1_i >> rsVal2_i[5:0];
            3'd7:    alu_s = ($signed(rsVal1_i) < $signed(rsVal2_i)) ? 64'd1 : 64'd0;
            default: alu_s = 64'd0;
        endcase
    end

    // Ops in flight: +1 per accept, -1 per pop, unchanged when both happen.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            occ_r <= {OCC_W{1'b0}};
        end else if (acc_s && !pop_s) begin
            occ_r <= occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
        end else if (pop_s && !acc_s) begin
            occ_r <= occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
        end else begin
            occ_r <= occ_r;
        end
    end

    // The buffer write lands one cycle before the result may be requested,
    // so the delay line holds LATENCY-1 stages (none for LATENCY=1).
    generate
        if (LATENCY == 1) begin : g_direct
            assign wr_vld_s = acc_s;
            assign wr_tag_s = rsTag_i;
            assign wr_res_s = alu_s;
        end else begin : g_pipe
            logic [LATENCY-2:0]    pv_r;
            logic [ROBsizeLog-1:0] pt_r [LATENCY-1];
            logic [63:0]           pr_r [LATENCY-1];

            // Stage valid bits; cleared on reset so dropped ops never reach the buffer.
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    pv_r <= '0;
                end else begin
                    pv_r <= {pv_r[LATENCY-2:0], acc_s} ;
                end
            end

            // Stage payload; only meaningful where the matching valid bit is set.
            always_ff @(posedge clk_i) begin
                pt_r[0] <= rsTag_i;
                pr_r[0] <= alu_s;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    pt_r[i] <= pt_r[i-1];
                    pr_r[i] <= pr_r[i-1];
                end
            end

            assign wr_vld_s = pv_r[LATENCY-2];
            assign wr_tag_s = pt_r[LATENCY-2];
            assign wr_res_s = pr_r[LATENCY-2];
        end
    endgenerate

    // Result buffer storage; the credit scheme guarantees a free slot on write.
    always_ff @(posedge clk_i) begin
        if (wr_vld_s) begin
            tag_mem_r[wr_ptr_r] <= wr_tag_s;
            res_mem_r[wr_ptr_r] <= wr_res_s;
        end else begin
            tag_mem_r[wr_ptr_r] <= tag_mem_r[wr_ptr_r];
            res_mem_r[wr_ptr_r] <= res_mem_r[wr_ptr_r];
        end
    end

    // Result buffer pointers and entry count.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {OCC_W{1'b0}};
        end else begin
            if (wr_vld_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_vld_s, pop_s})
                2'b10:   cnt_r <= cnt_r + {{(OCC_W-1){1'b0}}, 1'b1};
                2'b01:   cnt_r <= cnt_r - {{(OCC_W-1){1'b0}}, 1'b1};
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Present the buffer head; an empty buffer drives zeros so no tag can match.
    always_comb begin
        cdbReq_o = 1'b0;
        cdbTag_o = {ROBsizeLog{1'b0}};
        cdbVal_o = 65'h0;
        if (cnt_r != {OCC_W{1'b0}}) begin
            cdbReq_o = 1'b1;
            cdbTag_o = tag_mem_r[rd_ptr_r];
            cdbVal_o = {1'b1, res_mem_r[rd_ptr_r]};
        end else begin
            cdbReq_o = 1'b0;
            cdbTag_o = {ROBsizeLog{1'b0}};
            cdbVal_o = 65'h0;
        end
    end

endmodule

// File: doc/exec_cdb_broadcaster.md
Name: exec_cdb_broadcaster

Overview:
- Functional-unit back end that takes issued operations from a reservation-station group and executes them in a fixed-latency ALU pipeline.
- Buffers results in order and broadcasts each one on the common data bus (CDB) as a tag plus a 65-bit value with a valid bit.
- It is the producer side of the CDB interface that reservation stations snoop. It also supplies the stall back-pressure that reservation stations obey on issue.

Parameters:
- ROBsize, 32, number of ROB entries.
- ROBsizeLog, $clog2(ROBsize+1), tag width.
- LATENCY, 3, cycles from acceptance to earliest CDB request; legal range 1..8.
- BUF_DEPTH, 4, maximum operations in flight (pipeline plus result buffer); must be >= 1.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- rsVal1_i  in  64  operand A
- rsVal2_i  in  64  operand B
- rsCommands_i  in  10  operation; [2:0] is the opcode, [9:3] are ignored
- rsTag_i  in  ROBsizeLog  destination ROB tag
- rsReady_i  in  1  reservation station presents an issuable op
- stall_o  out  1  reservation stations must not issue
- cdbGrant_i  in  1  CDB arbiter grant for this unit
- cdbReq_o  out  1  result pending at buffer head
- cdbTag_o  out  ROBsizeLog  broadcast tag
- cdbVal_o  out  65  [64] valid, [63:0] result

Behaviour:
- Reset: the following clear on the clock edge where reset_i=1, and all in-flight and buffered results are discarded:
  - occupancy counter occ -> 0
  - pipeline valids
  - result buffer (empty)
- After reset, outputs are cdbReq_o=0, cdbTag_o=0, cdbVal_o=0.
- stall_o=1 combinationally whenever reset_i=1.
- Accept: an op is accepted in a cycle where rsReady_i=1 and stall_o=0. Operands, opcode and tag are captured at that edge.
- stall_o = reset_i | (occ == BUF_DEPTH). occ is the registered value; a pop in the same cycle does not lower stall_o in that cycle (no same-cycle credit return).
- occ update:
  - +1 on accept only
  - -1 on pop only
  - unchanged on simultaneous accept and pop
  - never exceeds BUF_DEPTH, never underflows.
- Opcodes (64-bit, wrap-around, no flags):
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLL: A << B[5:0]
  - 6 SRL: logical A >> B[5:0]
  - 7 SLT: signed A<B gives 64'd1, else 64'd0
- Pipeline: an op accepted in cycle t produces cdbReq_o=1 no earlier than cycle t+LATENCY. This is exact when the buffer ahead of it is empty and no earlier result is waiting.
  - The pipeline never stalls internally; the credit scheme guarantees buffer space.
- Result buffer: in-order FIFO of {tag, result}, depth BUF_DEPTH.
  - Results broadcast in acceptance order.
  - The head is stable while cdbReq_o=1 and cdbGrant_i=0.
- Broadcast:
  - cdbReq_o = buffer non-empty.
  - cdbTag_o = head tag.
  - cdbVal_o = {1'b1, head result} while cdbReq_o=1.
  - When the buffer is empty: cdbTag_o=0 and cdbVal_o=65'h0 (valid bit low, so no spurious tag match).
- Pop: occurs at the edge where cdbReq_o=1 and cdbGrant_i=1. The next entry, if any, is presented in the following cycle, so one result per cycle under continuous grant.
- cdbGrant_i while cdbReq_o=0 is ignored.
- Simultaneous pipeline write into an empty buffer and grant: the grant applies only to the entry visible in that cycle. A new entry becomes visible the cycle after its write.
- Reset mid-operation: everything is dropped, no broadcast of dropped ops, and stall_o deasserts the cycle after reset_i falls.
- rsVal/rsTag/rsCommands are don't-care when not accepting.

Test Plan:
- Single op: after reset, accept ADD tag=5, A=10, B=11, grant held 1 -> cdbReq_o=1 exactly LATENCY cycles later with cdbTag_o=5, cdbVal_o=65'h1_0000_0000_0000_0015; one cycle of cdbReq_o, then cdbVal_o=0.
- Opcode sweep: A=64'hFFFF_FFFF_FFFF_FFFE (-2), B=3 across opcodes 0..7 -> results:
  - ADD 1
  - SUB 64'hFFFF_FFFF_FFFF_FFFB
  - AND 2
  - OR 64'hFFFF_FFFF_FFFF_FFFF
  - XOR 64'hFFFF_FFFF_FFFF_FFFD
  - SLL 64'hFFFF_FFFF_FFFF_FFF0
  - SRL 64'h1FFF_FFFF_FFFF_FFFF
  - SLT 1
- Fill and back-pressure: grant=0, rsReady_i=1 continuously with tags 1..6 offered -> exactly BUF_DEPTH=4 accepted (tags 1-4) and stall_o=1 from the cycle after the 4th accept. Raising grant broadcasts tags 1,2,3,4 on consecutive cycles, and stall_o drops the cycle after the first pop.
- Simultaneous accept/pop: occ=4 with grant=1 -> stall_o stays 1 during the pop cycle, then 0. Thereafter steady-state accepts keep occ at its value with one broadcast per cycle and no loss or duplication (scoreboard on tags).
- Reset mid-flight: accept tags 7 and 8, assert reset_i for 1 cycle before either broadcasts -> no cdbReq_o for 7 or 8, occ=0, stall_o=1 during reset and 0 the next cycle.
- Grant without request: cdbGrant_i=1 with an empty buffer for 10 cycles -> cdbVal_o stays 65'h0 and state is unchanged.
